pio_master: RTL and testbench
=============================

// Module: pio_master
// PURPOSE
//  PIO bus initiator: turns single host register requests into the serial PIO protocol
//  (pio_start / pio_rw / pio_addr_wdata) consumed by each block's pio2reg_bus, and collects
//  pio_ack / pio_rvalid / pio_rdata back. Sits on the host/CPU side; one transaction in flight.
//  Guards against missing responses with a timeout.
// PARAMETERS
//  PIO_NBITS      32    width of pio_addr_wdata / pio_rdata (`PIO_RANGE)
//  TIMEOUT_CYCLES 1024  WAIT cycles before a transaction is aborted with error (>=2)
//  TO_NBITS       11    width of timeout counter, must hold TIMEOUT_CYCLES
// PORTS
//  clk             in   1          clock; single clock domain
//  `RESET_SIG      in   1          asynchronous, active-high reset
//  req_valid       in   1          host request present
//  req_ready       out  1          master idle, request accepted when req_valid&req_ready
//  req_rw          in   1          1=read, 0=write
//  req_addr        in   PIO_NBITS  register address
//  req_wdata       in   PIO_NBITS  write data (ignored for reads)
//  resp_valid      out  1          response present, held until resp_ready
//  resp_ready      in   1          host consumes response
//  resp_rdata      out  PIO_NBITS  read data; all-ones on timeout; 0 for writes
//  resp_err        out  1          1 = timeout abort
//  stray_err       out  1          sticky: pio_ack/pio_rvalid seen with no transaction pending
//  pio_start       out  1          1-cycle pulse marking address phase
//  pio_rw          out  1          1=read, 0=write; valid with pio_start
//  pio_addr_wdata  out  PIO_NBITS  address in start cycle, write data in next cycle
//  pio_ack         in   1          slave completion (write)
//  pio_rvalid      in   1          slave read data valid
//  pio_rdata       in   PIO_NBITS  slave read data
// BEHAVIOUR
//  - All outputs registered except req_ready = (state==IDLE). Reset: state IDLE, req_ready=1,
//    pio_start=0, pio_rw=0, pio_addr_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0,
//    stray_err=0, timeout counter=0. Reset asserted mid-transaction aborts it; no response.
//  - FSM: IDLE -> ADDR -> (write) DATA -> WAIT -> RESP -> IDLE; (read) ADDR -> WAIT.
//  - IDLE: on req_valid, latch rw/addr/wdata; next cycle is ADDR.
//  - ADDR: pio_start=1, pio_rw=req_rw, pio_addr_wdata=addr, exactly one cycle.
//  - DATA (write only): pio_start=0, pio_addr_wdata=wdata, one cycle.
//  - WAIT: pio_start=0, pio_addr_wdata=0; counter cleared on entry, +1 per WAIT cycle.
//    Write completes on pio_ack; read completes on pio_rvalid (pio_rdata captured that cycle);
//    pio_ack during a read WAIT is ignored. Completion and count==TIMEOUT_CYCLES-1 in the same
//    cycle: completion wins. Count==TIMEOUT_CYCLES-1 without completion: abort, resp_err=1,
//    resp_rdata=all-ones. Counter saturates, never wraps.
//  - RESP: resp_valid=1, resp_rdata/resp_err stable until resp_ready; on resp_valid&resp_ready
//    return to IDLE (req_ready=1 the following cycle; back-to-back min 1 idle cycle).
//  - Latency (accept in cycle A): pio_start in A+1; write data in A+2, WAIT from A+3;
//    read WAIT from A+2. Completion sampled in cycle W -> resp_valid in W+1.
//  - pio_ack or pio_rvalid in IDLE/ADDR/DATA/RESP (or late after timeout) sets stray_err;
//    cleared only by reset; does not affect FSM.
// TESTING
//  1 write addr=0x0000_1234 wdata=0xA5A5_5A5A, ack 3 cycles into WAIT -> pio_start 1 cycle
//    rw=0 addr, next cycle 0xA5A5_5A5A, resp_valid 1 cycle after ack, err=0, rdata=0.
//  2 read addr=0x40, pio_rvalid with 0xCAFE_F00D 5 cycles into WAIT -> resp_rdata=0xCAFE_F00D,
//    err=0; pio_ack pulse during WAIT ignored.
//  3 TIMEOUT_CYCLES=16, no response -> resp_valid 16 cycles after WAIT entry, err=1,
//    rdata=0xFFFF_FFFF; subsequent write completes normally.
//  4 resp_ready low 10 cycles -> resp held stable, req_ready=0, pending req_valid not accepted
//    until 1 cycle after handshake.
//  5 pio_ack in IDLE, then late pio_rvalid after timeout -> stray_err=1 sticky, no extra
//    resp_valid; cleared only by reset.
//  6 assert reset in WAIT of a read -> all outputs at reset values asynchronously; after
//    release, new read to 0x80 completes correctly.

Source files
------------

// File: rtl/pio_master.sv
// pio_master: PIO bus initiator; converts one host register request at a time into the
// serial PIO protocol and returns the slave response, aborting with an error on timeout.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   req_valid/req_ready        host request handshake (req_ready = master idle)
//   req_rw/req_addr/req_wdata  request: 1=read 0=write, address, write data
//   resp_valid/resp_ready      response handshake, response held until consumed
//   resp_rdata/resp_err        read data (0 for writes, all-ones on timeout), timeout flag
//   stray_err                  sticky: slave response seen with nothing pending
//   pio_start/pio_rw           address-phase pulse and direction
//   pio_addr_wdata             address in start cycle, write data in the following cycle
//   pio_ack/pio_rvalid/pio_rdata  slave write completion, read valid, read data
module pio_master #(
    parameter int PIO_NBITS      = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_NBITS       = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rw,
    input  logic [PIO_NBITS-1:0] req_addr,
    input  logic [PIO_NBITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [PIO_NBITS-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 stray_err,
    output logic                 pio_start,
    output logic                 pio_rw,
    output logic [PIO_NBITS-1:0] pio_addr_wdata,
    input  logic                 pio_ack,
    input  logic                 pio_rvalid,
    input  logic [PIO_NBITS-1:0] pio_rdata
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, RESP} state_t;

    localparam logic [TO_NBITS-1:0] TO_LAST = TO_NBITS'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic                 rw_q;
    logic [PIO_NBITS-1:0] wdata_q;
    logic [TO_NBITS-1:0]  cnt;
    logic                 done;

    assign req_ready = (state == IDLE);
    // A read only completes on rvalid; an ack seen during a read wait is ignored.
    assign done = rw_q ? pio_rvalid : pio_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rw_q           <= 1'b0;
            wdata_q        <= '0;
            cnt            <= '0;
            pio_start      <= 1'b0;
            pio_rw         <= 1'b0;
            pio_addr_wdata <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            stray_err      <= 1'b0;
        end else begin
            // Any slave response outside the wait window has no owner.
            if ((pio_ack || pio_rvalid) && state != WAIT)
                stray_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state          <= ADDR;
                        rw_q           <= req_rw;
                        wdata_q        <= req_wdata;
                        pio_start      <= 1'b1;
                        pio_rw         <= req_rw;
                        pio_addr_wdata <= req_addr;
                    end
                end
                ADDR: begin
                    pio_start      <= 1'b0;
                    cnt            <= '0;
                    state          <= rw_q ? WAIT : DATA;
                    pio_addr_wdata <= rw_q ? '0 : wdata_q;
                end
                DATA: begin
                    state          <= WAIT;
                    cnt            <= '0;
                    pio_addr_wdata <= '0;
                end
                WAIT: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (done) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= rw_q ? pio_rdata : '0;
                    end else if (cnt == TO_LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '1;
                    end
                    if (cnt != TO_LAST)
                        cnt <= cnt + 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pio_master.sv
// tb_pio_master: directed scoreboard bench for pio_master (timeout shortened to 16 cycles).
module tb_pio_master;
    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0, req_rw = 0, resp_ready = 1;
    logic [31:0] req_addr = 0, req_wdata = 0, pio_rdata = 0;
    logic        pio_ack = 0, pio_rvalid = 0;
    logic        req_ready, resp_valid, resp_err, stray_err, pio_start, pio_rw;
    logic [31:0] resp_rdata, pio_addr_wdata;

    int          vec = 0;
    int          miscmp = 0;
    logic [32:0] exp_q[$];
    logic [32:0] e;

    pio_master #(.PIO_NBITS(32), .TIMEOUT_CYCLES(16), .TO_NBITS(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .stray_err(stray_err),
        .pio_start(pio_start), .pio_rw(pio_rw), .pio_addr_wdata(pio_addr_wdata),
        .pio_ack(pio_ack), .pio_rvalid(pio_rvalid), .pio_rdata(pio_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops one expected response per host handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_resp", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e[31:0]);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_pio_start", {31'd0, pio_start}, 32'd0);
        chk("rst_pio_rw", {31'd0, pio_rw}, 32'd0);
        chk("rst_pio_addr_wdata", pio_addr_wdata, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_stray_err", {31'd0, stray_err}, 32'd0);
    endtask

    // Issue a request and check the address/data phases; returns in the first WAIT cycle.
    task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!req_ready && n < 100) begin
            tick(1);
            n++;
        end
        chk("req_ready_bound", {31'd0, req_ready}, 32'd1);
        req_valid = 1; req_rw = rw; req_addr = a; req_wdata = d;
        tick(1);
        req_valid = 0;
        chk("pio_start", {31'd0, pio_start}, 32'd1);
        chk("pio_rw", {31'd0, pio_rw}, {31'd0, rw});
        chk("pio_addr", pio_addr_wdata, a);
        tick(1);
        chk("pio_start_drop", {31'd0, pio_start}, 32'd0);
        if (!rw) begin
            chk("pio_wdata", pio_addr_wdata, d);
            tick(1);
        end
        chk("wait_bus_zero", pio_addr_wdata, 32'd0);
    endtask

    task automatic pulse_ack();
        pio_ack = 1;
        tick(1);
        pio_ack = 0;
    endtask

    task automatic pulse_rv(input logic [31:0] d);
        pio_rvalid = 1; pio_rdata = d;
        tick(1);
        pio_rvalid = 0; pio_rdata = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        chk_reset_outs();
        @(posedge clk);
        #1 rst = 0;
        tick(1);

        // 1: write, ack 3 cycles into WAIT
        issue(1'b0, 32'h0000_1234, 32'hA5A5_5A5A);
        tick(3);
        chk("t1_no_early_resp", {31'd0, resp_valid}, 32'd0);
        exp_q.push_back({1'b0, 32'h0});
        pulse_ack();
        chk("t1_resp_valid", {31'd0, resp_valid}, 32'd1);
        tick(1);

        // 2: read, stray-looking ack in WAIT ignored, rvalid 5 cycles in
        issue(1'b1, 32'h0000_0040, 32'h0);
        tick(2);
        pulse_ack();
        chk("t2_ack_ignored", {31'd0, resp_valid}, 32'd0);
        tick(2);
        exp_q.push_back({1'b0, 32'hCAFE_F00D});
        pulse_rv(32'hCAFE_F00D);
        chk("t2_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("t2_no_stray", {31'd0, stray_err}, 32'd0);
        tick(1);

        // 3: timeout after 16 WAIT cycles, then a normal write
        issue(1'b1, 32'h0000_0100, 32'h0);
        exp_q.push_back({1'b1, 32'hFFFF_FFFF});
        tick(15);
        chk("t3_not_yet", {31'd0, resp_valid}, 32'd0);
        tick(1);
        chk("t3_timeout_resp", {31'd0, resp_valid}, 32'd1);
        tick(1);
        issue(1'b0, 32'h0000_0008, 32'h1357_9BDF);
        exp_q.push_back({1'b0, 32'h0});
        pulse_ack();
        chk("t3_after_write", {31'd0, resp_valid}, 32'd1);
        tick(1);

        // 4: host backpressure; pending request must wait for the handshake
        resp_ready = 0;
        issue(1'b1, 32'h0000_0020, 32'h0);
        exp_q.push_back({1'b0, 32'h1111_2222});
        pulse_rv(32'h1111_2222);
        req_valid = 1; req_rw = 0; req_addr = 32'h0000_0200; req_wdata = 32'h0000_0033;
        for (int i = 0; i < 10; i++) begin
            chk("t4_held_valid", {31'd0, resp_valid}, 32'd1);
            chk("t4_held_rdata", resp_rdata, 32'h1111_2222);
            chk("t4_req_ready_low", {31'd0, req_ready}, 32'd0);
            chk("t4_no_start", {31'd0, pio_start}, 32'd0);
            tick(1);
        end
        resp_ready = 1;
        tick(1);
        chk("t4_idle_after_hs", {31'd0, req_ready}, 32'd1);
        chk("t4_start_not_yet", {31'd0, pio_start}, 32'd0);
        tick(1);
        req_valid = 0;
        chk("t4_start", {31'd0, pio_start}, 32'd1);
        chk("t4_addr", pio_addr_wdata, 32'h0000_0200);
        tick(1);
        chk("t4_wdata", pio_addr_wdata, 32'h0000_0033);
        tick(1);
        exp_q.push_back({1'b0, 32'h0});
        pulse_ack();
        chk("t4_resp", {31'd0, resp_valid}, 32'd1);
        tick(1);

        // 5a: ack with nothing pending sets sticky stray_err
        chk("t5_stray_clear", {31'd0, stray_err}, 32'd0);
        pulse_ack();
        tick(1);
        chk("t5_stray_set", {31'd0, stray_err}, 32'd1);
        chk("t5_no_resp", {31'd0, resp_valid}, 32'd0);

        // 6: reset during a read WAIT, then a clean read
        issue(1'b1, 32'h0000_0300, 32'h0);
        tick(3);
        #2 rst = 1;
        #1;
        chk_reset_outs();
        @(posedge clk);
        #1 rst = 0;
        tick(1);
        issue(1'b1, 32'h0000_0080, 32'h0);
        tick(1);
        exp_q.push_back({1'b0, 32'h0BAD_BEEF});
        pulse_rv(32'h0BAD_BEEF);
        chk("t6_resp", {31'd0, resp_valid}, 32'd1);
        tick(1);

        // 5b: late rvalid after a timeout is stray and produces no response
        issue(1'b1, 32'h0000_0400, 32'h0);
        exp_q.push_back({1'b1, 32'hFFFF_FFFF});
        tick(17);
        chk("t5b_stray_before", {31'd0, stray_err}, 32'd0);
        pulse_rv(32'h1234_5678);
        tick(1);
        chk("t5b_stray_set", {31'd0, stray_err}, 32'd1);
        chk("t5b_no_resp", {31'd0, resp_valid}, 32'd0);
        tick(3);
        chk("t5b_stray_sticky", {31'd0, stray_err}, 32'd1);

        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
